// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: LOADER_PARITY_EN (even-parity check on loaded bytes).
package fetch_pkg;

  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam logic [N-1:0] HLT_OPCODE = 8'hFF;
  localparam logic [N-1:0] NOP_OPCODE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_e;

  // True when data plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [N-1:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Loader handshake and core fetch bus of the instruction fetch unit.
// Optional feature macro: LOADER_PARITY_EN adds ld_par.
interface inst_fetch_unit_if;
  import fetch_pkg::*;

  logic          ld_valid;
  logic [N-1:0]  ld_data;
  logic          ld_last;
  logic          ld_ready;
`ifdef LOADER_PARITY_EN
  logic          ld_par;
`endif
  logic          fetch_req;
  logic [AW-1:0] fetch_pc;
  logic          fetch_valid;
  logic [N-1:0]  fetch_instr;

  modport master (
    output ld_valid, ld_data, ld_last,
`ifdef LOADER_PARITY_EN
    output ld_par,
`endif
    output fetch_req, fetch_pc,
    input  ld_ready, fetch_valid, fetch_instr
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
`ifdef LOADER_PARITY_EN
    input  ld_par,
`endif
    input  fetch_req, fetch_pc,
    output ld_ready, fetch_valid, fetch_instr
  );

endinterface

// File: rtl/inst_fetch_unit_prog_mem.sv
// Program memory: DEPTH x N register file, valid bitmap and registered read port.
// Entries never written since the last clear read back as HLT_OPCODE.
module prog_mem
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [N-1:0]     rdata_q, rdata_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    valid_d = valid_q;
    rdata_d = rdata_q;
    if (clear) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[waddr] = 1'b1;
    end
    if (re) begin
      rdata_d = valid_q[raddr] ? mem_q[raddr] : HLT_OPCODE;
    end
  end

  // NOTE: storage has no reset; stale contents are masked by the valid bitmap.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdata_q <= NOP_OPCODE;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Program loader and fetch stage: IDLE/LOAD/RUN/HALT control, counters and error flags.
// Optional feature macro: LOADER_PARITY_EN (ld_par input, sticky err_parity output).
module inst_fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_unit_if.slave  bus,
  input  logic              restart,
  input  logic              clear,
  output logic              running,
  output logic              halt_seen,
  output logic [AW:0]       load_count,
  output logic              err_overflow
`ifdef LOADER_PARITY_EN
  ,
  output logic              err_parity
`endif
);

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic        err_ovf_q, err_ovf_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        running_q, running_d;
  logic        halt_q, halt_d;
  logic        err_par_q, err_par_d;

  logic        accept;
  logic        par_ok;
  logic        mem_we;
  logic        halting;
  logic        rd_en;
  logic [N-1:0] rd_data;

  assign bus.ld_ready = (state_q == IDLE) || (state_q == LOAD);
  // clear wins over a same-cycle byte: it is dropped, not stored.
  assign accept       = bus.ld_valid && bus.ld_ready && !clear;

`ifdef LOADER_PARITY_EN
  assign par_ok = even_parity_ok(bus.ld_data, bus.ld_par);
`else
  assign par_ok = 1'b1;
`endif

  assign mem_we  = accept && par_ok;
  assign halting = fetch_valid_q && (rd_data == HLT_OPCODE);
  // A request alongside the HLT result would otherwise leak a pulse into HALT.
  assign rd_en   = bus.fetch_req && (state_q == RUN) && !halting && !clear;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    err_par_d = err_par_q;
    if (clear) begin
      state_d   = IDLE;
      count_d   = '0;
      err_ovf_d = 1'b0;
      err_par_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (mem_we) count_d = count_q + 1'b1;
            else        err_par_d = 1'b1;
            if (bus.ld_last) begin
              state_d = RUN;
            end else if (count_d == (AW+1)'(DEPTH)) begin
              state_d   = RUN;
              err_ovf_d = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end
        end
        RUN:     if (halting) state_d = HALT;
        HALT:    if (restart) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    fetch_valid_d = rd_en;
    running_d     = (state_d == RUN);
    halt_d        = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      err_ovf_q     <= 1'b0;
      err_par_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      running_q     <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      err_ovf_q     <= err_ovf_d;
      err_par_q     <= err_par_d;
      fetch_valid_q <= fetch_valid_d;
      running_q     <= running_d;
      halt_q        <= halt_d;
    end
  end

  prog_mem u_prog_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .we    (mem_we),
    .waddr (count_q[AW-1:0]),
    .wdata (bus.ld_data),
    .re    (rd_en),
    .raddr (bus.fetch_pc),
    .rdata (rd_data)
  );

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_instr = rd_data;
  assign running         = running_q;
  assign halt_seen       = halt_q;
  assign load_count      = count_q;
  assign err_overflow    = err_ovf_q;
`ifdef LOADER_PARITY_EN
  assign err_parity      = err_par_q;
`else
  logic unused_err_par;
  assign unused_err_par  = err_par_q;
`endif

endmodule
